systolic_feed_scheduler: RTL and testbench
==========================================

// Module: systolic_feed_scheduler
// PURPOSE
//   Sequences the read strobes of ROWS per-row input FIFOs that feed the left edge of the systolic array.
//   Issues a diagonally skewed read schedule: row r starts r cycles after row 0, and each row reads LEN elements.
//   Freezes the whole schedule on any FIFO underrun, so the skew between rows is always preserved.
//   Sits between the top-level control (start/abort) and the FIFO read-pointer logic of each row.
// PARAMETERS
//   ROWS   4  number of row FIFOs / array rows fed
//   LEN_W  5  width of the per-row element count input
// PORTS
//   clk         in   1          clock, rising edge
//   reset_n     in   1          asynchronous, active-low reset
//   start       in   1          launch one feed pass; sampled only in IDLE
//   abort       in   1          cancel the current pass; sampled in every state
//   len         in   LEN_W      elements per row (L); latched on accepted start
//   fifo_empty  in   ROWS       per-row FIFO empty flags
//   read        out  ROWS       per-row FIFO read strobes
//   row_valid   out  ROWS       per-row data-valid toward the array (read delayed by 1 cycle)
//   busy        out  1          a pass is in progress
//   stall       out  1          schedule frozen this cycle due to underrun
//   done        out  1          1-cycle pulse at normal completion
// BEHAVIOUR
// - Reset (async, reset_n=0)
//   - Immediately: state=IDLE, counter t=0, latched L=0.
//   - read, row_valid, busy, stall, done all 0; read drops with no clock edge.
//   - Mid-pass reset discards the pass; no done pulse.
// - FSM states: IDLE, RUN, DONE.
//   - IDLE -> RUN: start=1 & abort=0 & len!=0 at a clock edge; latch L=len, t=0.
//   - IDLE -> DONE: start=1 & abort=0 & len==0 (empty pass; no reads issued).
//   - RUN -> DONE: t reaches L+ROWS-1 (see counter rule).
//   - DONE -> IDLE: unconditionally, next cycle.
//   - RUN/DONE -> IDLE on abort=1; abort has priority over every other transition.
//   - start is ignored outside IDLE.
// - Schedule (RUN, combinational from registered state):
//   - sched[r] = (t >= r) & (t < r+L).
//   - stall = |(sched & fifo_empty).
//   - read[r] = sched[r] & ~stall & ~abort.
// - Counter t: width LEN_W+$clog2(ROWS)+1.
//   - In RUN, t increments by 1 per cycle when stall=0 and holds when stall=1.
//   - When t+1 == L+ROWS-1 with stall=0, go to DONE.
//   - Unstalled pass length: L+ROWS-1 RUN cycles; each row reads exactly L times.
// - Outputs per state:
//   - row_valid: registered copy of read; cleared by reset and in the cycle after an abort.
//   - busy = 1 in RUN and DONE; 0 in IDLE.
//   - done = 1 only in DONE (single-cycle pulse); stall = 0 outside RUN.
// - Boundary conditions:
//   - Stall in the last RUN cycle delays DONE until the missing FIFO is non-empty.
//   - Empty flags of rows with sched[r]=0 never cause a stall.
//   - abort in the same cycle as the last read: that read is suppressed; no done pulse.
//   - start and abort together in IDLE: start is ignored.
// TESTING (ROWS=4, LEN_W=5; cycle k = k-th cycle after the start edge)
//   1. len=3, FIFOs never empty:
//      read = 0001,0011,0111,1110,1100,1000 in cycles 0..5; done=1 in cycle 6;
//      busy=1 in cycles 0..6; row_valid equals read shifted by 1 cycle.
//   2. len=3, fifo_empty[2]=1 during cycles 2..3:
//      stall=1 and read=0000 in cycles 2,3; schedule resumes with 0111 in cycle 4;
//      done=1 in cycle 8; each row gets 3 reads.
//   3. len=0: no read asserted; done=1 in cycle 0; IDLE in cycle 1.
//   4. len=5, abort=1 in cycle 3:
//      read=0000 in cycle 3; IDLE, busy=0, row_valid=0 from cycle 4; no done pulse.
//   5. reset_n=0 mid-pass in cycle 2, FIFOs full:
//      read/busy drop asynchronously; after release, start with len=2 gives a clean pass (done in cycle 5).
//   6. start re-pulsed in cycle 1 of a len=4 pass: ignored; exactly 4 reads per row; a single done pulse.

Source files
------------

// File: rtl/systolic_feed_scheduler.sv
// Diagonally skewed read-strobe sequencer for the per-row input FIFOs that
// feed the left edge of a systolic array. Row r starts r cycles after row 0
// and reads L elements. Any underrun on a scheduled row freezes the whole
// schedule, so the skew between rows is always preserved.
module systolic_feed_scheduler #(
  parameter int ROWS  = 4,
  parameter int LEN_W = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] len,
  input  logic [ROWS-1:0]  fifo_empty,
  output logic [ROWS-1:0]  read,
  output logic [ROWS-1:0]  row_valid,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  // Schedule step counter must reach L+ROWS-1 without wrapping.
  localparam int T_W = LEN_W + $clog2(ROWS) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [T_W-1:0]   t, t_next;
  logic [LEN_W-1:0] len_q, len_next;
  logic [T_W-1:0]   t_inc;
  logic [T_W-1:0]   last_step;
  logic [ROWS-1:0]  sched;

  assign t_inc     = t + T_W'(1);
  assign last_step = T_W'(len_q) + T_W'(ROWS - 1);

  // Which rows are inside their read window at the current schedule step.
  always_comb begin
    for (int r = 0; r < ROWS; r++) begin
      sched[r] = (state == RUN) && (t >= T_W'(r)) && (t < T_W'(r) + T_W'(len_q));
    end
  end

  // Only rows that are actually due this step can freeze the schedule; the
  // abort gate makes the strobes drop in the same cycle abort is seen.
  assign stall = (state == RUN) && |(sched & fifo_empty);
  assign read  = sched & {ROWS{~stall & ~abort}};
  assign busy  = (state != IDLE);
  assign done  = (state == DONE);

  // Next-state, counter and length-latch decisions.
  always_comb begin
    // NOTE: every variable gets its default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_next = state;
    t_next     = t;
    len_next   = len_q;
    unique case (state)
      IDLE: begin
        if (start && !abort) begin
          len_next   = len;
          t_next     = '0;
          state_next = (len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_next = IDLE;
        end else if (!stall) begin
          t_next = t_inc;
          if (t_inc == last_step) state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counter and latched length registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!reset_n) begin
      state <= IDLE;
      t     <= '0;
      len_q <= '0;
    end else begin
      state <= state_next;
      t     <= t_next;
      len_q <= len_next;
    end
  end

  // Data-valid toward the array follows the read strobe by one cycle; read is
  // already zero during an abort, so the cycle after an abort is clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) row_valid <= '0;
    else          row_valid <= read;
  end

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Self-checking bench for systolic_feed_scheduler (ROWS=4, LEN_W=5).
// A reference model precomputes the whole unstalled schedule of a pass as a
// list of row masks and walks it one entry per unstalled cycle.
module tb_systolic_feed_scheduler;

  localparam int ROWS  = 4;
  localparam int LEN_W = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2;

  logic             clk;
  logic             reset_n;
  logic             start;
  logic             abort;
  logic [LEN_W-1:0] len;
  logic [ROWS-1:0]  fifo_empty;
  logic [ROWS-1:0]  read;
  logic [ROWS-1:0]  row_valid;
  logic             busy;
  logic             stall;
  logic             done;

  systolic_feed_scheduler #(.ROWS(ROWS), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .abort      (abort),
    .len        (len),
    .fifo_empty (fifo_empty),
    .read       (read),
    .row_valid  (row_valid),
    .busy       (busy),
    .stall      (stall),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int              m_phase;
  logic [ROWS-1:0] m_q[$];
  int              m_idx;
  logic [ROWS-1:0] m_rv;

  // Per-pass observation
  int              k;
  int              done_cycle;
  int              done_count;
  int              rd_cnt[ROWS];
  logic [ROWS-1:0] rd_trace[64];
  logic            st_trace[64];
  bit              aborted;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = M_IDLE;
    m_idx   = 0;
    m_rv    = '0;
    m_q.delete();
  endtask

  // Row r wants elements at schedule steps r .. r+L-1.
  task automatic model_build(input int l);
    m_q.delete();
    for (int i = 0; i < l + ROWS - 1; i++) m_q.push_back('0);
    for (int r = 0; r < ROWS; r++)
      for (int e = 0; e < l; e++)
        m_q[r + e] = m_q[r + e] | ROWS'(1 << r);
    m_idx = 0;
  endtask

  task automatic clear_obs();
    k = 0;
    done_cycle = -1;
    done_count = 0;
    aborted = 1'b0;
    for (int r = 0; r < ROWS; r++) rd_cnt[r] = 0;
    for (int i = 0; i < 64; i++) begin
      rd_trace[i] = '0;
      st_trace[i] = 1'b0;
    end
  endtask

  // One clock cycle: compare outputs against the model, then advance the model.
  task automatic tick();
    logic [ROWS-1:0] e_read;
    logic            e_stall;
    logic [ROWS-1:0] want;
    e_read  = '0;
    e_stall = 1'b0;
    if (m_phase == M_RUN) begin
      want    = m_q[m_idx];
      e_stall = |(want & fifo_empty);
      e_read  = (e_stall || abort) ? '0 : want;
    end
    #1;
    check("read",      read,      e_read);
    check("row_valid", row_valid, m_rv);
    check("busy",      busy,      m_phase != M_IDLE);
    check("stall",     stall,     e_stall);
    check("done",      done,      m_phase == M_DONE);
    if (k >= 0 && k < 64) begin
      rd_trace[k] = read;
      st_trace[k] = stall;
    end
    if (done === 1'b1) begin
      done_cycle = k;
      done_count++;
    end
    for (int r = 0; r < ROWS; r++) if (read[r] === 1'b1) rd_cnt[r]++;
    if (abort && m_phase == M_RUN) aborted = 1'b1;
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      m_rv = e_read;
      case (m_phase)
        M_IDLE: if (start && !abort) begin
          if (len == '0) m_phase = M_DONE;
          else begin
            model_build(int'(len));
            m_phase = M_RUN;
          end
        end
        M_RUN: if (abort) m_phase = M_IDLE;
               else if (!e_stall) begin
                 m_idx++;
                 if (m_idx == m_q.size()) m_phase = M_DONE;
               end
        default: m_phase = M_IDLE;
      endcase
    end
    @(negedge clk);
    k++;
  endtask

  // Present start for one cycle in IDLE; cycle 0 is the one after that edge.
  task automatic launch(input int l);
    start = 1'b1;
    abort = 1'b0;
    len   = LEN_W'(l);
    tick();
    start = 1'b0;
    clear_obs();
  endtask

  initial begin
    reset_n    = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    len        = '0;
    fifo_empty = '0;
    model_reset();
    clear_obs();
    #1;
    check("rst_read",  read,      '0);
    check("rst_rv",    row_valid, '0);
    check("rst_busy",  busy,      0);
    check("rst_stall", stall,     0);
    check("rst_done",  done,      0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tick();

    // 1. len=3, FIFOs never empty
    launch(3);
    repeat (8) tick();
    check("t1_rd0", rd_trace[0], 4'b0001);
    check("t1_rd1", rd_trace[1], 4'b0011);
    check("t1_rd2", rd_trace[2], 4'b0111);
    check("t1_rd3", rd_trace[3], 4'b1110);
    check("t1_rd4", rd_trace[4], 4'b1100);
    check("t1_rd5", rd_trace[5], 4'b1000);
    check("t1_done_cycle", done_cycle, 6);
    check("t1_done_count", done_count, 1);
    for (int r = 0; r < ROWS; r++) check("t1_reads", rd_cnt[r], 3);

    // 2. len=3, row 2 empty in cycles 2..3
    launch(3);
    while (k < 10) begin
      fifo_empty = (k == 2 || k == 3) ? 4'b0100 : 4'b0000;
      tick();
    end
    fifo_empty = '0;
    check("t2_stall2", st_trace[2], 1);
    check("t2_stall3", st_trace[3], 1);
    check("t2_rd2",    rd_trace[2], 4'b0000);
    check("t2_rd4",    rd_trace[4], 4'b0111);
    check("t2_done_cycle", done_cycle, 8);
    for (int r = 0; r < ROWS; r++) check("t2_reads", rd_cnt[r], 3);

    // 3. len=0: empty pass
    launch(0);
    repeat (3) tick();
    check("t3_done_cycle", done_cycle, 0);
    for (int r = 0; r < ROWS; r++) check("t3_reads", rd_cnt[r], 0);

    // 4. len=5, abort in cycle 3
    launch(5);
    while (k < 8) begin
      abort = (k == 3);
      tick();
    end
    abort = 1'b0;
    check("t4_rd3", rd_trace[3], 4'b0000);
    check("t4_done_count", done_count, 0);

    // 5. asynchronous reset in cycle 2 of a pass
    launch(4);
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    check("t5_read_async", read, '0);
    check("t5_busy_async", busy, 0);
    check("t5_rv_async",   row_valid, '0);
    model_reset();
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    tick();
    launch(2);
    repeat (7) tick();
    check("t5_done_cycle", done_cycle, 5);
    for (int r = 0; r < ROWS; r++) check("t5_reads", rd_cnt[r], 2);

    // 6. start re-pulsed in cycle 1 of a len=4 pass
    launch(4);
    while (k < 10) begin
      start = (k == 1);
      len   = 5'd9;
      tick();
    end
    start = 1'b0;
    check("t6_done_count", done_count, 1);
    for (int r = 0; r < ROWS; r++) check("t6_reads", rd_cnt[r], 4);

    // Stall in the last RUN cycle delays DONE
    launch(2);
    while (k < 9) begin
      fifo_empty = (k == 4 || k == 5) ? 4'b1000 : 4'b0000;
      tick();
    end
    fifo_empty = '0;
    check("last_stall_done_cycle", done_cycle, 7);

    // Abort in the same cycle as the last read
    launch(3);
    while (k < 8) begin
      abort = (k == 5);
      tick();
    end
    abort = 1'b0;
    check("abort_last_rd5", rd_trace[5], 4'b0000);
    check("abort_last_done", done_count, 0);

    // start together with abort in IDLE is ignored
    start = 1'b1;
    abort = 1'b1;
    len   = 5'd3;
    tick();
    start = 1'b0;
    abort = 1'b0;
    tick();
    check("start_abort_idle", busy, 0);

    // Randomized passes: random empties, occasional abort, ignored starts
    for (int p = 0; p < 20; p++) begin
      int lv;
      int c;
      lv = (p == 19) ? 31 : int'($urandom_range(0, 10));
      launch(lv);
      c = 0;
      while ((busy || m_phase != M_IDLE) && c < 500) begin
        for (int r = 0; r < ROWS; r++) fifo_empty[r] = ($urandom_range(0, 4) == 0);
        abort = ($urandom_range(0, 59) == 0);
        start = (m_phase != M_IDLE) && ($urandom_range(0, 7) == 0);
        len   = LEN_W'($urandom_range(0, 31));
        tick();
        c++;
      end
      start      = 1'b0;
      abort      = 1'b0;
      fifo_empty = '0;
      check("rand_idle", busy, 0);
      if (!aborted) begin
        check("rand_done_count", done_count, 1);
        for (int r = 0; r < ROWS; r++) check("rand_reads", rd_cnt[r], lv);
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
